scsi_bus_arbiter: RTL and testbench
===================================

# scsi_bus_arbiter

Owns the A4092 local bus between the two parties that use it: Zorro host slave accesses to the NCR 53C710 registers, and 53C710 DMA (master) tenures on Zorro III. Converts the 53C710 BR/BG/BGACK handshake into a Zorro bus request, and gates slave strobe generation (`slave_en`). Includes deadlock avoidance when a host access collides with a pending master request. It also adds a grant timeout and a bus turnaround gap.

## Interface
Parameters:
- GRANT_TIMEOUT, 255: cycles to wait for Zorro grant before withdrawing request.
- TURNAROUND, 2: idle cycles inserted after every slave or master tenure (min 1).

Ports:
- CLKI  in  1  clock.
- IORST_n  in  1  reset, asynchronous, active-low.
- SCSI_BR_n  in  1  53C710 bus request, synchronous to CLKI.
- SCSI_BGACK_n  in  1  53C710 bus grant acknowledge, synchronous to CLKI.
- SCSI_BG_n  out  1  bus grant to 53C710.
- Z_BG_n  in  1  Zorro bus grant, asynchronous; 2-flop synchronized internally.
- Z_BR_n  out  1  Zorro bus request.
- slave_req  in  1  decoded host access to SCSI registers, level, held for the whole cycle.
- slave_en  out  1  permits the slave strobe generator to run.
- MYBUS_n  out  1  card owns Zorro bus.
- master_cycle  out  1  53C710 tenure active (drives data direction/DOE logic).
- grant_timeout  out  1  one-cycle pulse when a Zorro request is abandoned.

## Operation
- States: IDLE, SLAVE, ZREQ, SGRANT, MASTER, TURN. Reset state IDLE. Each state drives a fixed output set:
  - IDLE, TURN: all outputs negated.
  - SLAVE: `slave_en`=1.
  - ZREQ: `Z_BR_n`=0.
  - SGRANT: `MYBUS_n`=0, `SCSI_BG_n`=0.
  - MASTER: `MYBUS_n`=0, `master_cycle`=1.
- IDLE:
  - `slave_req`=1 → SLAVE. Slave wins a simultaneous `SCSI_BR_n`=0.
  - else `SCSI_BR_n`=0 → ZREQ; wait timer cleared.
- SLAVE: stays while `slave_req`=1; `slave_req`=0 → TURN.
- ZREQ: timer increments each cycle. Priority order:
  1. `slave_req`=1 → SLAVE. Request withdrawn; host access cannot complete while the card holds Zorro request.
  2. `SCSI_BR_n`=1 → IDLE.
  3. synchronized `Z_BG_n`=0 → SGRANT.
  4. timer = GRANT_TIMEOUT−1 → TURN, `grant_timeout` pulse.
- SGRANT:
  - `SCSI_BGACK_n`=0 → MASTER.
  - `SCSI_BR_n`=1 with `SCSI_BGACK_n`=1 → TURN (53C710 abandoned its request).
- MASTER:
  - `SCSI_BG_n` negated (68k style: grant drops once BGACK is seen).
  - `SCSI_BGACK_n`=1 → TURN.
  - `slave_req` is ignored (host is not bus master during the tenure).
- TURN: counter runs TURNAROUND cycles, then → IDLE. Requests arriving during TURN are held off and evaluated in IDLE.
- Timer width: $clog2(GRANT_TIMEOUT+1). Timer never wraps; it is cleared on ZREQ entry.
- After a timeout, a still-asserted `SCSI_BR_n` re-requests from IDLE after the turnaround.

## Timing
- All outputs are registered and decoded from next state, so an output changes on the same edge as the state.
- Reset values: `SCSI_BG_n`=1, `Z_BR_n`=1, `MYBUS_n`=1, `slave_en`=0, `master_cycle`=0, `grant_timeout`=0.
- `IORST_n` low clears state, counters and sync flops immediately, including mid-tenure.
- `slave_req` sampled high at edge n in IDLE → `slave_en`=1 after edge n. Same edge for SLAVE→TURN on `slave_req` low.
- `Z_BG_n` falling: 2 sync edges plus 1 state edge → `MYBUS_n`/`SCSI_BG_n` low 3 edges after the first sampling edge.
- `SCSI_BGACK_n` low at edge n → `SCSI_BG_n` high and `master_cycle` high after edge n.
- End of a tenure to next grant: at least TURNAROUND+1 edges.

## Structure
- Shared package a4092_pkg holds the state enum and the default values of GRANT_TIMEOUT and TURNAROUND.
- One sub-module, `sync2`: 2-flop synchronizer with reset value 1, instantiated for `Z_BG_n`.
- Remaining logic is a single FSM with timer and turnaround counter.

## Test plan
- Reset mid-MASTER: assert `IORST_n` low while `master_cycle`=1 → all outputs return to reset values without waiting for a clock.
- Slave only: `slave_req` high for 5 cycles → `slave_en` high the same 5 cycles, then 2 idle cycles before any grant.
- Full master tenure: `SCSI_BR_n`=0; `Z_BG_n`=0 after 10 cycles; BGACK low 2 cycles after BG; BGACK high after 20 cycles → check:
  - `Z_BR_n` low until the grant.
  - `MYBUS_n` low through the tenure.
  - `SCSI_BG_n` low exactly until BGACK.
  - 2 idle cycles after the tenure.
- Collision: `SCSI_BR_n`=0, then `slave_req`=1 while in ZREQ → `Z_BR_n` high on that edge, `slave_en`=1; after `slave_req` drops and 2 turnaround cycles, `Z_BR_n` reasserts.
- Timeout: GRANT_TIMEOUT=8, `Z_BG_n` held high → `Z_BR_n` low 8 cycles, single `grant_timeout` pulse, re-request after turnaround.
- Simultaneous `slave_req` and `SCSI_BR_n` in IDLE → SLAVE taken, `Z_BR_n` stays high.

Source files
------------

// File: rtl/a4092_pkg.sv
// Shared A4092 types: local bus arbiter state encoding and default timing parameters.
package a4092_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLAVE,
    ST_ZREQ,
    ST_SGRANT,
    ST_MASTER,
    ST_TURN
  } arb_state_t;

  localparam int GRANT_TIMEOUT_DEF = 255;
  localparam int TURNAROUND_DEF    = 2;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an active-low asynchronous input; resets to the negated level (1).
// Latency: two CLKI edges.
module sync2 (
  input  logic CLKI,
  input  logic IORST_n,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge CLKI or negedge IORST_n) begin
    if (!IORST_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/scsi_bus_arbiter.sv
// Local bus arbiter between host slave accesses and 53C710 DMA tenures on Zorro III.
// Outputs are registered from next state; Zorro grant reaches SCSI_BG_n three edges after first sampling.
module scsi_bus_arbiter
  import a4092_pkg::*;
#(
  parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
  parameter int TURNAROUND    = TURNAROUND_DEF
) (
  input  logic CLKI,
  input  logic IORST_n,
  input  logic SCSI_BR_n,
  input  logic SCSI_BGACK_n,
  output logic SCSI_BG_n,
  input  logic Z_BG_n,
  output logic Z_BR_n,
  input  logic slave_req,
  output logic slave_en,
  output logic MYBUS_n,
  output logic master_cycle,
  output logic grant_timeout
);

  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam int CW = $clog2(TURNAROUND + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] TURN_LAST  = CW'(TURNAROUND - 1);

  arb_state_t      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   turn_q, turn_d;
  logic            scsi_bg_n_q, scsi_bg_n_d;
  logic            z_br_n_q, z_br_n_d;
  logic            mybus_n_q, mybus_n_d;
  logic            slave_en_q, slave_en_d;
  logic            master_cycle_q, master_cycle_d;
  logic            grant_timeout_q, grant_timeout_d;
  logic            z_bg_n_s;

  sync2 u_zbg_sync (
    .CLKI    (CLKI),
    .IORST_n (IORST_n),
    .d       (Z_BG_n),
    .q       (z_bg_n_s)
  );

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    turn_d          = turn_q;
    grant_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slave_req) begin
          state_d = ST_SLAVE;
        end else if (!SCSI_BR_n) begin
          state_d = ST_ZREQ;
          timer_d = '0;
        end
      end
      ST_SLAVE: begin
        if (!slave_req) begin
          state_d = ST_TURN;
          turn_d  = '0;
        end
      end
      ST_ZREQ: begin
        timer_d = timer_q + TW'(1);
        // Host access must win: it cannot finish while we hold the Zorro request.
        if (slave_req) begin
          state_d = ST_SLAVE;
        end else if (SCSI_BR_n) begin
          state_d = ST_IDLE;
        end else if (!z_bg_n_s) begin
          state_d = ST_SGRANT;
        end else if (timer_q == TIMER_LAST) begin
          state_d         = ST_TURN;
          turn_d          = '0;
          grant_timeout_d = 1'b1;
        end
      end
      ST_SGRANT: begin
        if (!SCSI_BGACK_n) begin
          state_d = ST_MASTER;
        end else if (SCSI_BR_n) begin
          state_d = ST_TURN;
          turn_d  = '0;
        end
      end
      ST_MASTER: begin
        if (SCSI_BGACK_n) begin
          state_d = ST_TURN;
          turn_d  = '0;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = ST_IDLE;
        end else begin
          turn_d = turn_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    scsi_bg_n_d    = (state_d != ST_SGRANT);
    z_br_n_d       = (state_d != ST_ZREQ);
    mybus_n_d      = !((state_d == ST_SGRANT) || (state_d == ST_MASTER));
    slave_en_d     = (state_d == ST_SLAVE);
    master_cycle_d = (state_d == ST_MASTER);
  end

  always_ff @(posedge CLKI or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      turn_q          <= '0;
      scsi_bg_n_q     <= 1'b1;
      z_br_n_q        <= 1'b1;
      mybus_n_q       <= 1'b1;
      slave_en_q      <= 1'b0;
      master_cycle_q  <= 1'b0;
      grant_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      turn_q          <= turn_d;
      scsi_bg_n_q     <= scsi_bg_n_d;
      z_br_n_q        <= z_br_n_d;
      mybus_n_q       <= mybus_n_d;
      slave_en_q      <= slave_en_d;
      master_cycle_q  <= master_cycle_d;
      grant_timeout_q <= grant_timeout_d;
    end
  end

  assign SCSI_BG_n     = scsi_bg_n_q;
  assign Z_BR_n        = z_br_n_q;
  assign MYBUS_n       = mybus_n_q;
  assign slave_en      = slave_en_q;
  assign master_cycle  = master_cycle_q;
  assign grant_timeout = grant_timeout_q;

endmodule

// File: tb/tb_scsi_bus_arbiter.sv
// Bench for scsi_bus_arbiter: two instances (default timeout and GRANT_TIMEOUT=8) share stimulus
// and are compared every cycle against a phase-level reference model.
module tb_scsi_bus_arbiter;

  localparam int TA    = 2;
  localparam int G_A   = 255;
  localparam int G_B   = 8;

  localparam int P_IDLE   = 0;
  localparam int P_SLAVE  = 1;
  localparam int P_ZREQ   = 2;
  localparam int P_SGRANT = 3;
  localparam int P_MASTER = 4;
  localparam int P_TURN   = 5;

  typedef struct {
    int ph;
    int waited;
    int turn_left;
    bit s1;
    bit s2;
    bit pulse;
  } mdl_t;

  logic CLKI = 1'b0;
  logic IORST_n = 1'b1;
  logic SCSI_BR_n = 1'b1;
  logic SCSI_BGACK_n = 1'b1;
  logic Z_BG_n = 1'b1;
  logic slave_req = 1'b0;

  logic bg_a, zbr_a, mybus_a, sen_a, mc_a, gto_a;
  logic bg_b, zbr_b, mybus_b, sen_b, mc_b, gto_b;

  int checks = 0;
  int failures = 0;

  mdl_t ma, mb;

  always #5 CLKI = ~CLKI;

  scsi_bus_arbiter #(.GRANT_TIMEOUT(G_A), .TURNAROUND(TA)) dut_a (
    .CLKI(CLKI), .IORST_n(IORST_n), .SCSI_BR_n(SCSI_BR_n), .SCSI_BGACK_n(SCSI_BGACK_n),
    .SCSI_BG_n(bg_a), .Z_BG_n(Z_BG_n), .Z_BR_n(zbr_a), .slave_req(slave_req),
    .slave_en(sen_a), .MYBUS_n(mybus_a), .master_cycle(mc_a), .grant_timeout(gto_a)
  );

  scsi_bus_arbiter #(.GRANT_TIMEOUT(G_B), .TURNAROUND(TA)) dut_b (
    .CLKI(CLKI), .IORST_n(IORST_n), .SCSI_BR_n(SCSI_BR_n), .SCSI_BGACK_n(SCSI_BGACK_n),
    .SCSI_BG_n(bg_b), .Z_BG_n(Z_BG_n), .Z_BR_n(zbr_b), .slave_req(slave_req),
    .slave_en(sen_b), .MYBUS_n(mybus_b), .master_cycle(mc_b), .grant_timeout(gto_b)
  );

  wire [5:0] obs_a = {bg_a, zbr_a, mybus_a, sen_a, mc_a, gto_a};
  wire [5:0] obs_b = {bg_b, zbr_b, mybus_b, sen_b, mc_b, gto_b};

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.ph = P_IDLE; m.waited = 0; m.turn_left = 0;
    m.s1 = 1'b1; m.s2 = 1'b1; m.pulse = 1'b0;
    return m;
  endfunction

  // One clock of the arbitration rules; "waited" counts cycles already spent requesting.
  function automatic mdl_t mdl_step(mdl_t m, int g, bit sreq, bit br_n, bit bgack_n, bit zbg_n);
    mdl_t n = m;
    n.pulse = 1'b0;
    case (m.ph)
      P_IDLE:
        if (sreq) n.ph = P_SLAVE;
        else if (!br_n) begin n.ph = P_ZREQ; n.waited = 1; end
      P_SLAVE:
        if (!sreq) begin n.ph = P_TURN; n.turn_left = TA; end
      P_ZREQ:
        if (sreq) n.ph = P_SLAVE;
        else if (br_n) n.ph = P_IDLE;
        else if (!m.s2) n.ph = P_SGRANT;
        else if (m.waited == g) begin n.ph = P_TURN; n.turn_left = TA; n.pulse = 1'b1; end
        else n.waited = m.waited + 1;
      P_SGRANT:
        if (!bgack_n) n.ph = P_MASTER;
        else if (br_n) begin n.ph = P_TURN; n.turn_left = TA; end
      P_MASTER:
        if (bgack_n) begin n.ph = P_TURN; n.turn_left = TA; end
      default:
        if (m.turn_left <= 1) n.ph = P_IDLE;
        else n.turn_left = m.turn_left - 1;
    endcase
    n.s1 = zbg_n;
    n.s2 = m.s1;
    return n;
  endfunction

  function automatic logic [5:0] exp_vec(mdl_t m);
    return {m.ph != P_SGRANT, m.ph != P_ZREQ, !(m.ph == P_SGRANT || m.ph == P_MASTER),
            m.ph == P_SLAVE, m.ph == P_MASTER, m.pulse};
  endfunction

  always @(posedge CLKI or negedge IORST_n) begin
    if (!IORST_n) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= mdl_step(ma, G_A, slave_req, SCSI_BR_n, SCSI_BGACK_n, Z_BG_n);
      mb <= mdl_step(mb, G_B, slave_req, SCSI_BR_n, SCSI_BGACK_n, Z_BG_n);
    end
  end

  task automatic chk6(string tag, logic [5:0] obs, logic [5:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge CLKI);
    #1;
    chk6("model_a", obs_a, exp_vec(ma));
    chk6("model_b", obs_b, exp_vec(mb));
  endtask

  initial begin
    int sc, k, lows;

    // Reset state
    #1 IORST_n = 1'b0;
    #1;
    chk6("reset_a", obs_a, 6'b111000);
    chk6("reset_b", obs_b, 6'b111000);
    repeat (2) @(posedge CLKI);
    #2 IORST_n = 1'b1;
    repeat (2) cyc();

    // Slave only: five cycles of slave_en, then two idle turnaround cycles
    slave_req = 1'b1;
    sc = 0;
    repeat (5) begin cyc(); if (sen_a === 1'b1) sc++; end
    slave_req = 1'b0;
    chk_int("slave_en_cycles", sc, 5);
    repeat (2) begin cyc(); chk6("slave_turn_gap", obs_a, 6'b111000); end
    repeat (2) cyc();

    // Full master tenure on dut_a
    SCSI_BR_n = 1'b0;
    repeat (10) begin cyc(); chk_int("zbr_before_grant", int'(zbr_a), 0); end
    Z_BG_n = 1'b0;
    k = 0;
    while (bg_a !== 1'b0 && k < 20) begin cyc(); k++; end
    chk_int("grant_latency", k, 3);
    chk6("granted_a", obs_a, 6'b010000);
    repeat (2) begin cyc(); chk_int("bg_held", int'(bg_a), 0); end
    SCSI_BGACK_n = 1'b0;
    cyc();
    chk6("bgack_seen_a", obs_a, 6'b110010);
    repeat (19) begin cyc(); chk_int("mybus_tenure", int'(mybus_a), 0); end
    SCSI_BGACK_n = 1'b1;
    SCSI_BR_n = 1'b1;
    Z_BG_n = 1'b1;
    repeat (2) begin cyc(); chk6("tenure_turn_gap", obs_a, 6'b111000); end
    repeat (4) cyc();

    // Reset in the middle of a master tenure, between clock edges
    SCSI_BR_n = 1'b0;
    Z_BG_n = 1'b0;
    k = 0;
    while (bg_a !== 1'b0 && k < 20) begin cyc(); k++; end
    chk_int("grant2_seen", int'(bg_a), 0);
    SCSI_BGACK_n = 1'b0;
    cyc();
    chk_int("master_before_reset", int'(mc_a), 1);
    #3 IORST_n = 1'b0;
    #1;
    chk6("reset_mid_master_a", obs_a, 6'b111000);
    chk6("reset_mid_master_b", obs_b, 6'b111000);
    SCSI_BR_n = 1'b1;
    SCSI_BGACK_n = 1'b1;
    Z_BG_n = 1'b1;
    @(negedge CLKI);
    IORST_n = 1'b1;
    repeat (3) cyc();

    // Collision: host access while a Zorro request is pending
    SCSI_BR_n = 1'b0;
    repeat (2) cyc();
    chk_int("collision_zreq", int'(zbr_a), 0);
    slave_req = 1'b1;
    cyc();
    chk_int("collision_zbr_drop", int'(zbr_a), 1);
    chk_int("collision_slave_en", int'(sen_a), 1);
    cyc();
    slave_req = 1'b0;
    repeat (3) begin cyc(); chk_int("collision_held_off", int'(zbr_a), 1); end
    cyc();
    chk_int("collision_rerequest", int'(zbr_a), 0);
    SCSI_BR_n = 1'b1;
    repeat (4) cyc();

    // Grant timeout on the GRANT_TIMEOUT=8 instance
    SCSI_BR_n = 1'b0;
    lows = 0;
    k = 0;
    while (gto_b !== 1'b1 && k < 40) begin cyc(); if (zbr_b === 1'b0) lows++; k++; end
    chk_int("timeout_pulse_seen", int'(gto_b), 1);
    chk_int("timeout_zbr_low_cycles", lows, 8);
    cyc();
    chk_int("timeout_single_pulse", int'(gto_b), 0);
    k = 1;
    while (zbr_b !== 1'b0 && k < 20) begin cyc(); k++; end
    chk_int("timeout_rerequest_delay", k, 3);
    SCSI_BR_n = 1'b1;
    repeat (4) cyc();

    // Simultaneous host access and bus request in IDLE
    slave_req = 1'b1;
    SCSI_BR_n = 1'b0;
    cyc();
    chk_int("simul_slave_en", int'(sen_a), 1);
    chk_int("simul_zbr_high", int'(zbr_a), 1);
    cyc();
    chk_int("simul_zbr_still_high", int'(zbr_a), 1);
    slave_req = 1'b0;
    SCSI_BR_n = 1'b1;
    repeat (4) cyc();

    // Randomized traffic with sticky inputs
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) slave_req = ~slave_req;
      if ($urandom_range(0, 3) == 0) SCSI_BR_n = ~SCSI_BR_n;
      if ($urandom_range(0, 3) == 0) SCSI_BGACK_n = ~SCSI_BGACK_n;
      if ($urandom_range(0, 4) == 0) Z_BG_n = ~Z_BG_n;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
